// File: rtl/cbm2_cycle_sequencer_if.sv
// cbm2_cycle_sequencer_if: system bus timing bundle between the cycle sequencer
// and the chips that consume its strobes.
//   Configuration inputs : model, turbo, ipc_en, pause
//   Slot qualifiers      : cs_ram, cs_slow, cpu_we
//   Slot / frame state   : cycle[4:0], phase, io_cycle, cpu_cycle, cop_cycle, vid_cycle
//   Single-clock enables : en_cpu, en_cop, en_vid, en_io_n, en_io_p, en_pixel
//   SDRAM / system       : ram_ce, ram_we, refresh, pause_out, sys_reset
// master = sequencer side, slave = consumer side.
interface cbm2_cycle_sequencer_if;
    logic       model;
    logic       turbo;
    logic       ipc_en;
    logic       pause;
    logic       cs_ram;
    logic       cs_slow;
    logic       cpu_we;

    logic [4:0] cycle;
    logic       phase;
    logic       io_cycle;
    logic       cpu_cycle;
    logic       cop_cycle;
    logic       vid_cycle;
    logic       en_cpu;
    logic       en_cop;
    logic       en_vid;
    logic       en_io_n;
    logic       en_io_p;
    logic       en_pixel;
    logic       ram_ce;
    logic       ram_we;
    logic       refresh;
    logic       pause_out;
    logic       sys_reset;

    modport master (
        input  model, turbo, ipc_en, pause, cs_ram, cs_slow, cpu_we,
        output cycle, phase, io_cycle, cpu_cycle, cop_cycle, vid_cycle,
        output en_cpu, en_cop, en_vid, en_io_n, en_io_p, en_pixel,
        output ram_ce, ram_we, refresh, pause_out, sys_reset
    );

    modport slave (
        output model, turbo, ipc_en, pause, cs_ram, cs_slow, cpu_we,
        input  cycle, phase, io_cycle, cpu_cycle, cop_cycle, vid_cycle,
        input  en_cpu, en_cop, en_vid, en_io_n, en_io_p, en_pixel,
        input  ram_ce, ram_we, refresh, pause_out, sys_reset
    );
endinterface

// File: rtl/cbm2_cycle_sequencer.sv
// cbm2_cycle_sequencer: master time-slot sequencer for the CBM-II system bus and
// shared SDRAM port. Splits clk_sys into a repeating frame of 4-clock slots
// (EXT 0-3, CPU 4-7, COP 8-11, VID 12-15, plus NOP 16-17 on Business models) and
// derives every bus enable, SDRAM strobe, refresh pulse, pause gate and the
// synchronised system reset from it.
// Ports:
//   clk_sys  system clock
//   reset_n  asynchronous active-low reset
//   bus      cbm2_cycle_sequencer_if.master (inputs model/turbo/ipc_en/pause/
//            cs_ram/cs_slow/cpu_we, all slot and strobe outputs)
// Parameter: RFSH_FRAMES frames per refresh period (power of 2, >= 2).
// Optional feature macro: CBM2_SEQ_TURBO_EN enables 2 MHz CPU/COP slots on the
// Professional model when turbo is requested and VIC/SID is not selected.
module cbm2_cycle_sequencer #(
    parameter int unsigned RFSH_FRAMES = 8
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    cbm2_cycle_sequencer_if.master bus
);
    localparam int unsigned RW = $clog2(RFSH_FRAMES);
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] END_PRO = CW'(15);
    localparam logic [CW-1:0] END_BUS = CW'(17);

    logic [CW-1:0] cnt;
    logic [RW-1:0] rfsh_cnt;
    logic [1:0]    pix;
    logic          phase_q;
    logic          sys_en;
    logic          sys_reset_q;
    logic          refresh_q;

    logic [CW-1:0] end_val;
    logic [CW-1:0] cyc;
    logic          frame_end;
    logic          rfsh_zero;
    logic          pix_clr;
    logic          fast;
    logic          act;

    // Frame boundary and pause-gated slot index
    always_comb begin : frame_decode
        end_val   = bus.model ? END_BUS : END_PRO;
        // >= rather than == so a mid-frame switch to the shorter frame still wraps
        frame_end = (cnt >= end_val);
        rfsh_zero = (rfsh_cnt == '0);
        cyc       = sys_en ? cnt : '0;
        pix_clr   = sys_reset_q | ~sys_en | (cyc == end_val);
    end

    // Free-running slot counter
    always_ff @(posedge clk_sys or negedge reset_n) begin : slot_counter
        if (!reset_n) begin
            cnt <= '0;
        end else if (frame_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Per-frame state: phase, refresh period, pause gate, reset synchroniser
    always_ff @(posedge clk_sys or negedge reset_n) begin : frame_state
        if (!reset_n) begin
            phase_q     <= 1'b0;
            rfsh_cnt    <= '0;
            sys_en      <= 1'b0;
            sys_reset_q <= 1'b1;
            refresh_q   <= 1'b0;
        end else begin
            refresh_q <= frame_end & rfsh_zero;
            if (frame_end) begin
                phase_q     <= ~phase_q;
                rfsh_cnt    <= rfsh_cnt + RW'(1);
                // reset_n is high in this branch, so the synchronised reset clears
                sys_reset_q <= 1'b0;
                // pause is only sampled on refresh-period boundaries
                if (rfsh_zero) begin
                    sys_en <= ~bus.pause;
                end
            end
        end
    end

    // Pixel divider, realigned to the frame and held while paused or in reset
    always_ff @(posedge clk_sys or negedge reset_n) begin : pixel_counter
        if (!reset_n) begin
            pix <= '0;
        end else if (pix_clr) begin
            pix <= '0;
        end else begin
            pix <= pix + 2'd1;
        end
    end

`ifdef CBM2_SEQ_TURBO_EN
    // Professional runs at 2 MHz when turbo is requested, except for VIC/SID accesses
    always_comb begin : speed_select
        fast = bus.model | (bus.turbo & ~bus.cs_slow);
    end
`else
    logic unused_turbo;
    assign unused_turbo = bus.turbo ^ bus.cs_slow;

    always_comb begin : speed_select
        fast = bus.model;
    end
`endif

    // CPU/COP slots run every frame when fast, otherwise only in odd frames
    always_comb begin : slot_active
        act = phase_q | fast;
    end

    // Slot qualifiers, enables and SDRAM strobes decoded from the gated slot index
    always_comb begin : slot_decode
        bus.cycle     = cyc;
        bus.phase     = phase_q;
        bus.io_cycle  = (cyc <= CW'(3)) & (rfsh_cnt != RW'(1));
        bus.cpu_cycle = (cyc >= CW'(4)) & (cyc <= CW'(7)) & act;
        bus.cop_cycle = (cyc >= CW'(8)) & (cyc <= CW'(11)) & act;
        bus.vid_cycle = (cyc >= CW'(12)) & (cyc <= CW'(15));
        bus.en_io_n   = (cyc == CW'(6)) & act;
        bus.en_cpu    = (cyc == CW'(7)) & act;
        bus.en_io_p   = (cyc == CW'(8)) & act;
        bus.en_cop    = (cyc == CW'(11)) & bus.ipc_en;
        bus.en_vid    = (cyc == CW'(15));
        bus.en_pixel  = (pix == 2'd3) & ~bus.model;
        bus.ram_ce    = bus.cs_ram & (((cyc == CW'(4)) & act)
                                    | ((cyc == CW'(8)) & bus.ipc_en)
                                    | (cyc == CW'(12)));
        bus.ram_we    = bus.cpu_we & bus.cpu_cycle;
        bus.refresh   = refresh_q;
        bus.pause_out = ~sys_en;
        bus.sys_reset = sys_reset_q;
    end
endmodule

// File: tb/tb_cbm2_cycle_sequencer.sv
// tb_cbm2_cycle_sequencer: self-checking bench for cbm2_cycle_sequencer.
// Frame-level reference model: position in frame, frame number since reset and
// the pause gate; all slot outputs are derived from those with plain arithmetic.
// Honours CBM2_SEQ_TURBO_EN the same way as the design build.
module tb_cbm2_cycle_sequencer;
    localparam int unsigned RFSH_FRAMES = 8;
    localparam logic [20:0] RESET_VEC = {5'd0, 1'b0, 1'b1, 12'd0, 1'b1, 1'b1};
`ifdef CBM2_SEQ_TURBO_EN
    localparam int TURBO_GAP = 16;
`else
    localparam int TURBO_GAP = 32;
`endif

    logic clk_sys = 1'b0;
    logic reset_n;
    int   errors;
    int   checks;

    // reference model state
    int   m_pos;
    int   m_fnum;
    bit   m_en;

    always #5 clk_sys = ~clk_sys;

    cbm2_cycle_sequencer_if bus();

    cbm2_cycle_sequencer #(.RFSH_FRAMES(RFSH_FRAMES)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [20:0] observed_vec();
        return {bus.cycle, bus.phase, bus.io_cycle, bus.cpu_cycle, bus.cop_cycle,
                bus.vid_cycle, bus.en_cpu, bus.en_cop, bus.en_vid, bus.en_io_n,
                bus.en_io_p, bus.en_pixel, bus.ram_ce, bus.ram_we, bus.refresh,
                bus.pause_out, bus.sys_reset};
    endfunction

    function automatic logic [20:0] expected_vec();
        int c;
        int rf;
        bit ph;
        bit fast;
        bit act;
        bit cpu;
        bit cop;
        c  = m_en ? m_pos : 0;
        rf = m_fnum % int'(RFSH_FRAMES);
        ph = 1'(m_fnum % 2);
`ifdef CBM2_SEQ_TURBO_EN
        fast = bus.model | (bus.turbo & ~bus.cs_slow);
`else
        fast = bus.model;
`endif
        act = ph | fast;
        cpu = (c >= 4 && c <= 7) && act;
        cop = (c >= 8 && c <= 11) && act;
        return {5'(c), ph, (c <= 3 && rf != 1), cpu, cop, (c >= 12 && c <= 15),
                (c == 7 && act), (c == 11 && bus.ipc_en), (c == 15),
                (c == 6 && act), (c == 8 && act),
                (m_en && (m_pos % 4 == 3) && !bus.model),
                (bus.cs_ram && ((c == 4 && act) || (c == 8 && bus.ipc_en) || c == 12)),
                (bus.cpu_we && cpu),
                (m_fnum > 0 && rf == 1 && m_pos == 0),
                !m_en, (m_fnum == 0)};
    endfunction

    task automatic model_reset();
        m_pos  = 0;
        m_fnum = 0;
        m_en   = 1'b0;
    endtask

    // Called at a falling edge; ends at a falling edge with reset released.
    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
    endtask

    // Drive one clock's inputs; slow: 0/1 fixed cs_slow, 2 random.
    task automatic drive(input bit md, input bit tb, input bit pz, input int slow);
        bus.model   = md;
        bus.turbo   = tb;
        bus.pause   = pz;
        bus.cs_slow = (slow == 2) ? 1'($urandom) : 1'(slow);
        bus.ipc_en  = 1'($urandom);
        bus.cs_ram  = 1'($urandom);
        bus.cpu_we  = 1'($urandom);
        #1;
    endtask

    // Advance the model across one rising edge, then return at the falling edge.
    task automatic step();
        int end_v;
        end_v = bus.model ? 17 : 15;
        if (m_pos >= end_v) begin
            if (m_fnum % int'(RFSH_FRAMES) == 0) m_en = !bus.pause;
            m_pos = 0;
            m_fnum++;
        end else begin
            m_pos++;
        end
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk_sys);
        #1;
        obs = observed_vec();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values observed=%h expected=%h", obs, RESET_VEC);
        end
        drive(1'b1, 1'b1, 1'b1, 2);
        @(posedge clk_sys);
        #1;
        obs = observed_vec();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_hold observed=%h expected=%h", obs, RESET_VEC);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_business_frame();
        logic [20:0] obs;
        logic [20:0] exp;
        int last = -1;
        apply_reset();
        for (int i = 0; i < 18 * 12; i++) begin
            drive(1'b1, 1'($urandom), 1'b0, 2);
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL business_frame clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (i == 17 || i == 18) begin
                checks++;
                if (bus.sys_reset !== ((i == 17) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL business_sys_reset clk=%0d observed=%b", i, bus.sys_reset);
                end
            end
            if (bus.en_vid === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != 18) begin
                        errors++;
                        $display("FAIL business_en_vid_gap observed=%0d expected=18", i - last);
                    end
                end
                last = i;
            end
            step();
        end
    endtask

    task automatic test_professional();
        logic [20:0] obs;
        logic [20:0] exp;
        int last = -1;
        apply_reset();
        for (int i = 0; i < 16 * 12; i++) begin
            drive(1'b0, 1'b0, 1'b0, 2);
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL professional clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (bus.en_cpu === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != 32) begin
                        errors++;
                        $display("FAIL professional_en_cpu_gap observed=%0d expected=32", i - last);
                    end
                end
                last = i;
            end
            step();
        end
    endtask

    task automatic test_turbo();
        logic [20:0] obs;
        logic [20:0] exp;
        int last = -1;
        int gap;
        apply_reset();
        for (int i = 0; i < 16 * 20; i++) begin
            if (i == 160) last = -1;
            gap = (i < 160) ? TURBO_GAP : 32;
            drive(1'b0, 1'b1, 1'b0, (i < 160) ? 0 : 1);
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL turbo clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (bus.en_cpu === 1'b1) begin
                if (last >= 0) begin
                    checks++;
                    if (i - last != gap) begin
                        errors++;
                        $display("FAIL turbo_en_cpu_gap clk=%0d observed=%0d expected=%0d", i, i - last, gap);
                    end
                end
                last = i;
            end
            step();
        end
    endtask

    task automatic test_refresh();
        logic [20:0] obs;
        logic [20:0] exp;
        int pulses = 0;
        apply_reset();
        for (int i = 0; i < 16 * 8 * 3; i++) begin
            drive(1'b0, 1'($urandom), 1'b0, 2);
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL refresh clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (bus.refresh === 1'b1) pulses++;
            if (i == 17 || i == 33) begin
                checks++;
                if (bus.io_cycle !== ((i == 33) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL refresh_io_cycle clk=%0d observed=%b", i, bus.io_cycle);
                end
            end
            step();
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL refresh_count observed=%0d expected=3", pulses);
        end
    endtask

    task automatic test_pause();
        logic [20:0] obs;
        logic [20:0] exp;
        apply_reset();
        for (int i = 0; i < 16 * 20; i++) begin
            drive(1'b0, 1'($urandom), (i >= 40 && i < 180), 2);
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL pause clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (i == 143 || i == 144 || i == 271 || i == 272) begin
                checks++;
                if (bus.pause_out !== ((i == 144 || i == 271) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL pause_out_edge clk=%0d observed=%b", i, bus.pause_out);
                end
            end
            if (i == 147 || i == 150) begin
                checks++;
                if ({bus.cycle, bus.en_pixel} !== 6'd0) begin
                    errors++;
                    $display("FAIL paused_frozen clk=%0d cycle=%0d en_pixel=%b expected 0/0",
                             i, bus.cycle, bus.en_pixel);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [20:0] obs;
        logic [20:0] exp;
        apply_reset();
        for (int i = 0; i < 29; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2);
            bus.ipc_en = 1'b1;
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midreset_run clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (i < 28) step();
        end
        reset_n = 1'b0;
        #1;
        obs = observed_vec();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL midreset_async observed=%h expected=%h", obs, RESET_VEC);
        end
        @(posedge clk_sys);
        #1;
        obs = observed_vec();
        checks++;
        if (obs !== RESET_VEC) begin
            errors++;
            $display("FAIL midreset_no_cop observed=%h expected=%h", obs, RESET_VEC);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 18 * 4; i++) begin
            drive(1'b1, 1'($urandom), 1'b0, 2);
            obs = observed_vec();
            exp = expected_vec();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL midreset_recover clk=%0d observed=%h expected=%h", i, obs, exp);
            end
            if (i == 17 || i == 18) begin
                checks++;
                if (bus.sys_reset !== ((i == 17) ? 1'b1 : 1'b0)) begin
                    errors++;
                    $display("FAIL midreset_sys_reset clk=%0d observed=%b", i, bus.sys_reset);
                end
            end
            step();
        end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset_n     = 1'b0;
        bus.model   = 1'b0;
        bus.turbo   = 1'b0;
        bus.ipc_en  = 1'b0;
        bus.pause   = 1'b0;
        bus.cs_ram  = 1'b0;
        bus.cs_slow = 1'b0;
        bus.cpu_we  = 1'b0;
        model_reset();
        test_reset();
        test_business_frame();
        test_professional();
        test_turbo();
        test_refresh();
        test_pause();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
